// File: rtl/jpt_pkg.sv
// Shared definitions for the EJTAG PC-trace probe decoder: PCST codes,
// collector states, trace record layout and slot-count helper.
package jpt_pkg;

    localparam logic [2:0] PCST_STL = 3'b000;
    localparam logic [2:0] PCST_JMP = 3'b001;
    localparam logic [2:0] PCST_BRT = 3'b010;
    localparam logic [2:0] PCST_EXP = 3'b011;
    localparam logic [2:0] PCST_SEQ = 3'b100;
    localparam logic [2:0] PCST_TST = 3'b101;
    localparam logic [2:0] PCST_TSQ = 3'b110;
    localparam logic [2:0] PCST_DBM = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR0 = 3'd1,
        ST_ADDR1 = 3'd2,
        ST_ADDR2 = 3'd3,
        ST_ADDR3 = 3'd4,
        ST_VEC   = 3'd5
    } col_state_t;

    // Stall count is appended outside the struct because its width is a
    // per-instance parameter.
    typedef struct packed {
        logic [11:0] slots;
        logic [2:0]  nslot;
        logic        addrv;
        logic        xvec;
        logic [30:0] addr;
        logic        aerr;
        logic        lost;
    } rec_t;

    localparam int REC_BASE_W = 12 + 3 + 1 + 1 + 31 + 1 + 1;

    function automatic int rec_w(input int stlw);
        return REC_BASE_W + stlw;
    endfunction

    // Encoding 3 is reserved on the transmitter and decodes as 4 slots.
    function automatic logic [2:0] mlog2_nslot(input logic [1:0] mlog2);
        case (mlog2)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ptd_fifo.sv
// First-word-fall-through record FIFO; data visible the cycle after push.
// Push while full is refused unless a pop happens in the same cycle.
module ptd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_dat,
    output logic                       o_full,
    input  logic                       i_pop,
    output logic                       o_vld,
    output logic [WIDTH-1:0]           o_dat,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_empty;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok  = i_pop & ~w_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

    assign o_vld   = ~w_empty;
    assign o_dat   = r_mem[r_rd_ptr[AW-1:0]];
    assign o_level = LW'(r_wr_ptr - r_rd_ptr);

endmodule

// File: rtl/jpt_decode.sv
// PC-trace pin decoder: one record per valid sample, queued in an FWFT FIFO
// (VALID one cycle after the sample, drops when full). Option: PTD_STL_COMPRESS_EN.
module jpt_decode
    import jpt_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int STLW  = 8
) (
    input  logic                       SYSCLK,
    input  logic                       RESET_D1_R,
    input  logic [1:0]                 CFG_EJTMLOG2,
    input  logic                       JPT_DREN_R,
    input  logic [11:0]                JPT_PCST_DR,
    input  logic [7:0]                 JPT_TPC_DR,
    input  logic                       PTD_CLR_P,
    output logic                       PTD_REC_VALID,
    input  logic                       PTD_REC_READY,
    output logic [11:0]                PTD_REC_SLOTS,
    output logic [2:0]                 PTD_REC_NSLOT,
    output logic                       PTD_REC_ADDRV,
    output logic                       PTD_REC_XVEC,
    output logic [30:0]                PTD_REC_ADDR,
    output logic                       PTD_REC_AERR,
    output logic                       PTD_REC_LOST,
    output logic [STLW-1:0]            PTD_REC_STLCNT,
    output logic                       PTD_OVF_R,
    output logic                       PTD_BUSY_R,
    output logic [$clog2(DEPTH+1)-1:0] PTD_LEVEL
);

    localparam int RW = rec_w(STLW);

    col_state_t      r_state;
    col_state_t      w_state_nxt;
    logic [23:0]     r_addr_lo;
    logic            r_lost;
    logic            r_ovf;

    logic [2:0]      w_nslot;
    logic [11:0]     w_slot_mask;
    logic [11:0]     w_slots;
    logic            w_aerr;
    logic            w_addrv;
    logic            w_xvec;
    logic [30:0]     w_addr;
    rec_t            w_rec;
    logic [STLW-1:0] w_stlcnt;

    logic            w_wr;
    logic            w_full;
    logic            w_pop;
    logic            w_drop;
    logic            w_fifo_vld;
    logic [RW-1:0]   w_rd_dat;
    rec_t            w_rd_rec;

    assign w_nslot     = mlog2_nslot(CFG_EJTMLOG2);
    assign w_slot_mask = (w_nslot == 3'd1) ? 12'h007 :
                         (w_nslot == 3'd2) ? 12'h03F : 12'hFFF;
    // Inactive slots become STL (000), which the collector ignores.
    assign w_slots     = JPT_PCST_DR & w_slot_mask;

    always_ff @(posedge SYSCLK) begin
        if (RESET_D1_R) begin
            r_state <= ST_IDLE;
        end else if (JPT_DREN_R) begin
            r_state <= w_state_nxt;
        end
    end

    // The sample's TPC is consumed by the collection already in flight; only
    // then are this sample's slots walked, oldest first.
    always_comb begin
        col_state_t v_st;
        w_aerr = 1'b0;
        case (r_state)
            ST_ADDR0: v_st = ST_ADDR1;
            ST_ADDR1: v_st = ST_ADDR2;
            ST_ADDR2: v_st = ST_ADDR3;
            default:  v_st = ST_IDLE;
        endcase
        for (int i = 0; i < 4; i++) begin
            case (w_slots[3*i +: 3])
                PCST_JMP: begin
                    if (v_st != ST_IDLE) w_aerr = 1'b1;
                    v_st = ST_ADDR0;
                end
                PCST_EXP: begin
                    if (v_st != ST_IDLE) w_aerr = 1'b1;
                    v_st = ST_VEC;
                end
                PCST_DBM: begin
                    if (v_st != ST_IDLE) begin
                        w_aerr = 1'b1;
                        v_st   = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
        w_state_nxt = v_st;
    end

    always_comb begin
        w_addrv = 1'b0;
        w_xvec  = 1'b0;
        w_addr  = '0;
        case (r_state)
            ST_ADDR3: begin
                w_addrv = 1'b1;
                w_addr  = {JPT_TPC_DR[6:0], r_addr_lo};
            end
            ST_VEC: begin
                w_addrv = 1'b1;
                w_xvec  = 1'b1;
                w_addr  = {28'd0, JPT_TPC_DR[2:0]};
            end
            default: ;
        endcase
        w_rec.slots = w_slots;
        w_rec.nslot = w_nslot;
        w_rec.addrv = w_addrv;
        w_rec.xvec  = w_xvec;
        w_rec.addr  = w_addr;
        w_rec.aerr  = w_aerr;
        w_rec.lost  = r_lost;
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET_D1_R) begin
            r_addr_lo <= '0;
        end else if (JPT_DREN_R) begin
            case (r_state)
                ST_ADDR0: r_addr_lo[7:0]   <= JPT_TPC_DR;
                ST_ADDR1: r_addr_lo[15:8]  <= JPT_TPC_DR;
                ST_ADDR2: r_addr_lo[23:16] <= JPT_TPC_DR;
                default: ;
            endcase
        end
    end

`ifdef PTD_STL_COMPRESS_EN
    logic [STLW-1:0] r_stlcnt;
    logic            w_skip;

    assign w_skip   = (w_slots == 12'd0) && !w_addrv;
    assign w_wr     = JPT_DREN_R & ~w_skip;
    assign w_stlcnt = r_stlcnt;

    // A dropped record keeps the run count so the next stored record reports it.
    always_ff @(posedge SYSCLK) begin
        if (RESET_D1_R) begin
            r_stlcnt <= '0;
        end else if (JPT_DREN_R && w_skip) begin
            if (r_stlcnt != '1) r_stlcnt <= r_stlcnt + STLW'(1);
        end else if (w_wr && !w_drop) begin
            r_stlcnt <= '0;
        end
    end
`else
    assign w_wr     = JPT_DREN_R;
    assign w_stlcnt = '0;
`endif

    assign w_pop  = w_fifo_vld & PTD_REC_READY;
    assign w_drop = w_wr & w_full & ~w_pop;

    always_ff @(posedge SYSCLK) begin
        if (RESET_D1_R) begin
            r_lost <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_drop)    r_lost <= 1'b1;
            else if (w_wr) r_lost <= 1'b0;
            if (w_drop)         r_ovf <= 1'b1;
            else if (PTD_CLR_P) r_ovf <= 1'b0;
        end
    end

    ptd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RW)
    ) u_fifo (
        .i_clk      (SYSCLK),
        .i_rst      (RESET_D1_R),
        .i_push     (w_wr),
        .i_push_dat ({w_rec, w_stlcnt}),
        .o_full     (w_full),
        .i_pop      (w_pop),
        .o_vld      (w_fifo_vld),
        .o_dat      (w_rd_dat),
        .o_level    (PTD_LEVEL)
    );

    // Record outputs read as zero whenever nothing is queued.
    assign w_rd_rec       = w_rd_dat[RW-1:STLW];
    assign PTD_REC_VALID  = w_fifo_vld;
    assign PTD_REC_SLOTS  = w_fifo_vld ? w_rd_rec.slots : '0;
    assign PTD_REC_NSLOT  = w_fifo_vld ? w_rd_rec.nslot : '0;
    assign PTD_REC_ADDRV  = w_fifo_vld & w_rd_rec.addrv;
    assign PTD_REC_XVEC   = w_fifo_vld & w_rd_rec.xvec;
    assign PTD_REC_ADDR   = w_fifo_vld ? w_rd_rec.addr : '0;
    assign PTD_REC_AERR   = w_fifo_vld & w_rd_rec.aerr;
    assign PTD_REC_LOST   = w_fifo_vld & w_rd_rec.lost;
    assign PTD_REC_STLCNT = w_fifo_vld ? w_rd_dat[STLW-1:0] : '0;

    assign PTD_OVF_R  = r_ovf;
    assign PTD_BUSY_R = (r_state != ST_IDLE);

endmodule

// File: doc/jpt_decode.md
Name: jpt_decode

Overview:
- Probe-side decoder for the EJTAG PC-trace pin stream driven by the jpt transmitter: JPT_PCST_DR (up to 4 three-bit PCST slots per sample) and JPT_TPC_DR (target-address / vector nibbles).
- Reconstructs per-sample trace records, reassembles multi-sample jump target addresses and exception vectors, and buffers records in a FIFO with a valid/ready drain port.
- Used in the debug-probe model and in silicon trace-capture builds, sitting on the trace pins alongside jpt.

Parameters:
- DEPTH, 8, record FIFO depth in entries (power of 2, minimum 2).
- STLW, 8, width of the stall-run counter (optional feature only).

Ports:
- SYSCLK  in  1  core clock; trace sampled on rising edge.
- RESET_D1_R  in  1  reset, synchronous, active-high.
- CFG_EJTMLOG2  in  2  slots per sample = 1<<value; value 3 treated as 2.
- JPT_DREN_R  in  1  sample strobe; pins valid when 1.
- JPT_PCST_DR  in  12  PCST slots; slot0 = [2:0] (oldest) .. slot3 = [11:9].
- JPT_TPC_DR  in  8  TPC pins [8:1].
- PTD_CLR_P  in  1  one-cycle pulse; clears PTD_OVF_R.
- PTD_REC_VALID  out  1  record available.
- PTD_REC_READY  in  1  consumer accepts record.
- PTD_REC_SLOTS  out  12  raw PCST of sample; unused slots forced to 0.
- PTD_REC_NSLOT  out  3  active slot count (1, 2 or 4).
- PTD_REC_ADDRV  out  1  address/vector completed in this sample.
- PTD_REC_XVEC  out  1  1 = exception vector, 0 = jump target.
- PTD_REC_ADDR  out  31  target [31:1], or vector in [3:1] with upper bits 0.
- PTD_REC_AERR  out  1  collection aborted (overlap or DBM).
- PTD_REC_LOST  out  1  at least one record dropped before this one.
- PTD_REC_STLCNT  out  STLW  compressed stall samples preceding record.
- PTD_OVF_R  out  1  sticky FIFO overflow.
- PTD_BUSY_R  out  1  address collection in progress.
- PTD_LEVEL  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- PCST codes: STL=000, JMP=001, BRT=010, EXP=011, SEQ=100, TST=101, TSQ=110, DBM=111.
- Reset: all outputs 0; FIFO empty; collector IDLE; LOST, OVF and stall counter cleared.
- A reset asserted mid-collection discards the partial address; no record is emitted for it.
- Slots are processed oldest first, only those below NSLOT.
- Collector FSM states: IDLE, ADDR0..ADDR3, VEC.
  - JMP in IDLE -> ADDR0, starting on the next valid sample. The TPC value in the detecting sample belongs to the previous owner.
  - ADDRn captures TPC into address chunk n: [8:1], [16:9], [24:17], [31:25] (TPC bit 8 ignored in ADDR3).
  - ADDR3 completes -> ADDRV=1, XVEC=0 on that sample's record -> IDLE.
  - EXP in IDLE -> VEC; the next valid sample captures TPC[3:1] -> ADDRV=1, XVEC=1 -> IDLE.
  - Second JMP/EXP while busy, including two in one sample: AERR=1 on the current record; collection restarts for the newest JMP/EXP.
  - DBM while busy: AERR=1, go to IDLE. DBM in IDLE: no effect.
  - State advances only on JPT_DREN_R=1 samples.
- One record is written per valid sample, at the sampling edge; PTD_REC_VALID rises the following cycle. FIFO is first-word fall-through.
- FIFO full and no pop: record dropped, PTD_OVF_R set, LOST=1 on the next written record.
- FIFO full with pop in the same cycle: write accepted, no drop.
- PTD_CLR_P and a new overflow in the same cycle: overflow wins.
- PTD_BUSY_R is 1 in any non-IDLE state.

Optional Feature:
- Macro: PTD_STL_COMPRESS_EN.
- With the macro: a valid sample whose active slots are all STL and has ADDRV=0 is not written; the stall counter increments, saturating at all-ones. The next written record carries the count in STLCNT, and the counter then clears.
- Without the macro: every valid sample is written and STLCNT is tied to 0.

Decomposition:
- Package jpt_pkg: PCST code constants, collector state enum, record struct/width constant (12+3+1+1+31+1+1+STLW), MLOG2-to-NSLOT function.
- Sub-module ptd_fifo: synchronous FWFT FIFO with full/empty/level and simultaneous push/pop.

Test Plan:
- MLOG2=2, PCST=0x90C (SEQ,JMP,SEQ,SEQ), then TPC 0x34,0x12,0xCD,0xAB on the next 4 samples with PCST=0x924 (all SEQ) -> 5 records; the 5th has ADDRV=1, XVEC=0, ADDR=0x2BCD1234; BUSY high for 4 samples.
- MLOG2=0, PCST=0x003 (EXP), next sample TPC=0x05 -> second record ADDRV=1, XVEC=1, ADDR=0x5.
- JMP, then one TPC chunk, then a sample containing DBM -> that record AERR=1, ADDRV=0; BUSY=0 afterwards.
- DEPTH=8, READY=0, 10 valid samples -> LEVEL=8, OVF=1. Drain, next sample -> LOST=1 on that record. PTD_CLR_P -> OVF=0.
- With PTD_STL_COMPRESS_EN, MLOG2=1: 5 samples of PCST=0x000, then PCST=0x024 -> a single record with STLCNT=5, NSLOT=2.
- Reset pulse during ADDR2 -> outputs 0, FIFO empty; the next JMP+4 chunks decode cleanly.
